clock_ctrl: RTL and testbench

Run/halt/single-step controller for the three-phase clock generator. It owns the generator's `halt` input and changes it only on CPU-cycle boundaries, so that a stopped machine always freezes with `internal_clock` high and `cycle_clock` low, and resumes with a clean `cycle_clock` pulse. It sits between the debug/front-panel logic (run, halt and step requests) plus the CPU stop sources (breakpoint, HLT instruction) and the clock generator. It also counts the CPU cycles issued.

---
 rtl/clock_ctrl_pkg.sv | 18 +
 rtl/phase_tracker.sv | 29 ++
 rtl/clock_ctrl.sv | 131 +++++++++++++
 tb/tb_clock_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared types and phase constants for the run/halt/step clock controller.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STOPPING = 2'd1,
        HALTED   = 2'd2,
        STEP     = 2'd3
    } state_t;

    localparam logic [1:0] PH_LAST  = 2'd2;
    localparam logic [1:0] PH_BOUND = 2'd2;

    function automatic logic [1:0] ph_next(input logic [1:0] p);
        return (p == PH_LAST) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/phase_tracker.sv
// Mirror of the generator's mod-3 phase counter, boundary strobe and
// sticky lockstep check of internal_clock against the mirror.
module phase_tracker
    import clock_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       halt,
    input  logic       internal_clock,
    output logic [1:0] ph,
    output logic       boundary,
    output logic       phase_err
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ph        <= 2'd0;
            phase_err <= 1'b0;
        end else begin
            ph <= ph_next(ph);
            // While running, phase 0 of the mirror must see internal_clock high
            if (!halt && (internal_clock != (ph == 2'd0)))
                phase_err <= 1'b1;
        end
    end

    assign boundary = (ph == PH_BOUND);

endmodule

// File: rtl/clock_ctrl.sv
// Run/halt/single-step controller; moves the generator's halt input only
// on CPU-cycle boundaries and counts the CPU cycles issued.
module clock_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int STEP_W        = 8,
    parameter int CNT_W         = 32,
    parameter bit START_RUNNING = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_n,
    input  logic              bp_hit,
    input  logic              hlt_instr,
    input  logic              internal_clock,
    output logic              halt,
    output logic              halted,
    output logic [1:0]        state,
    output logic              step_done,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic              phase_err
);

    localparam state_t RST_STATE = START_RUNNING ? RUN : STOPPING;

    state_t            state_q, state_d;
    logic              halt_d, done_d;
    logic              p_stop_q, p_step_q, p_run_q;
    logic              p_stop_d, p_step_d, p_run_d;
    logic              stop_eff, step_eff, run_eff;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic [1:0]        ph;
    logic              boundary, at_bound;

    phase_tracker u_phase (
        .clk            (clk),
        .rst            (rst),
        .halt           (halt),
        .internal_clock (internal_clock),
        .ph             (ph),
        .boundary       (boundary),
        .phase_err      (phase_err)
    );

    assign at_bound = boundary && (ph == PH_BOUND);

    // A pulse landing on a boundary edge is serviced at that same edge
    assign stop_eff = p_stop_q | halt_req | bp_hit | hlt_instr;
    assign step_eff = p_step_q | step_req;
    assign run_eff  = p_run_q | run_req;

    always_comb begin
        state_d  = state_q;
        halt_d   = halt;
        done_d   = 1'b0;
        rem_d    = rem_q;
        p_stop_d = stop_eff;
        p_step_d = step_eff;
        p_run_d  = run_eff;
        if (at_bound) begin
            p_stop_d = 1'b0;
            p_step_d = 1'b0;
            p_run_d  = 1'b0;
            unique case (state_q)
                RUN: begin
                    if (stop_eff) begin
                        halt_d  = 1'b1;
                        state_d = HALTED;
                    end
                end
                STOPPING: begin
                    halt_d  = 1'b1;
                    state_d = HALTED;
                end
                HALTED: begin
                    if (step_eff) begin
                        halt_d  = 1'b0;
                        rem_d   = (step_n == '0) ? STEP_W'(1) : step_n;
                        state_d = STEP;
                    end else if (run_eff) begin
                        halt_d  = 1'b0;
                        state_d = RUN;
                    end
                end
                STEP: begin
                    if (stop_eff) begin
                        halt_d  = 1'b1;
                        state_d = HALTED;
                    end else if (rem_q == STEP_W'(1)) begin
                        halt_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = HALTED;
                    end else begin
                        rem_d = rem_q - STEP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RST_STATE;
            halt      <= 1'b0;
            step_done <= 1'b0;
            rem_q     <= '0;
            p_stop_q  <= 1'b0;
            p_step_q  <= 1'b0;
            p_run_q   <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            state_q   <= state_d;
            halt      <= halt_d;
            step_done <= done_d;
            rem_q     <= rem_d;
            p_stop_q  <= p_stop_d;
            p_step_q  <= p_step_d;
            p_run_q   <= p_run_d;
            if (at_bound && !halt)
                cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end

    assign state  = state_q;
    assign halted = (state_q == HALTED);

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: generator model, cycle-level
// reference model, step table and directed corner sequences.
module tb_clock_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run_req = 1'b0, halt_req = 1'b0, step_req = 1'b0;
    logic       bp_hit = 1'b0, hlt_instr = 1'b0;
    logic [7:0] step_n = 8'd0;
    logic       ic_force = 1'b0;
    logic [1:0] gph;

    logic        halt, halted, step_done, phase_err;
    logic [1:0]  state;
    logic [31:0] cycle_cnt;
    logic        halt4, halted4, step_done4, phase_err4;
    logic [1:0]  state4;
    logic [3:0]  cnt4;
    logic        halt0, halted0, step_done0, phase_err0;
    logic [1:0]  state0;
    logic [31:0] cnt0;
    logic        ic, ic4, ic0, cyc;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Clock generator model: free-running mod-3 counter, frozen outputs on halt
    always @(posedge clk) gph <= rst ? 2'd0 : (gph == 2'd2 ? 2'd0 : gph + 2'd1);
    assign ic  = ic_force | (halt ? 1'b1 : (gph == 2'd0));
    assign ic4 = halt4 ? 1'b1 : (gph == 2'd0);
    assign ic0 = halt0 ? 1'b1 : (gph == 2'd0);
    assign cyc = !halt && (gph == 2'd1);

    clock_ctrl dut (
        .clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req),
        .step_req(step_req), .step_n(step_n), .bp_hit(bp_hit),
        .hlt_instr(hlt_instr), .internal_clock(ic), .halt(halt),
        .halted(halted), .state(state), .step_done(step_done),
        .cycle_cnt(cycle_cnt), .phase_err(phase_err)
    );

    clock_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req),
        .step_req(step_req), .step_n(step_n), .bp_hit(bp_hit),
        .hlt_instr(hlt_instr), .internal_clock(ic4), .halt(halt4),
        .halted(halted4), .state(state4), .step_done(step_done4),
        .cycle_cnt(cnt4), .phase_err(phase_err4)
    );

    clock_ctrl #(.START_RUNNING(1'b0)) dut0 (
        .clk(clk), .rst(rst), .run_req(1'b0), .halt_req(1'b0),
        .step_req(1'b0), .step_n(8'd0), .bp_hit(1'b0),
        .hlt_instr(1'b0), .internal_clock(ic0), .halt(halt0),
        .halted(halted0), .state(state0), .step_done(step_done0),
        .cycle_cnt(cnt0), .phase_err(phase_err0)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edges counted since reset, boundary when k mod 3 == 2
    int     k;
    bit     m_halt, m_done, m_err, p_stop, p_step, p_run;
    int     m_state, m_rem;
    longint m_cnt;

    task automatic model_step();
        bit s, st, r;
        if (rst) begin
            k = 0; m_halt = 0; m_state = 0; m_done = 0; m_cnt = 0;
            m_err = 0; m_rem = 0; p_stop = 0; p_step = 0; p_run = 0;
            return;
        end
        s  = p_stop | halt_req | bp_hit | hlt_instr;
        st = p_step | step_req;
        r  = p_run | run_req;
        if (!m_halt && (ic != ((k % 3) == 0))) m_err = 1;
        m_done = 0;
        if ((k % 3) == 2) begin
            if (!m_halt) m_cnt++;
            if (m_state == 0 && s) begin
                m_halt = 1; m_state = 2;
            end else if (m_state == 2 && st) begin
                m_halt = 0; m_state = 3; m_rem = (step_n == 0) ? 1 : int'(step_n);
            end else if (m_state == 2 && r) begin
                m_halt = 0; m_state = 0;
            end else if (m_state == 3) begin
                if (s) begin
                    m_halt = 1; m_state = 2;
                end else if (m_rem == 1) begin
                    m_halt = 1; m_state = 2; m_done = 1;
                end else begin
                    m_rem--;
                end
            end
            p_stop = 0; p_step = 0; p_run = 0;
        end else begin
            p_stop = s; p_step = st; p_run = r;
        end
        k++;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        #1;
        chk("halt", halt, m_halt);
        chk("halted", halted, m_state == 2);
        chk("state", state, m_state);
        chk("step_done", step_done, m_done);
        chk("cycle_cnt", cycle_cnt, m_cnt & 64'hFFFF_FFFF);
        chk("phase_err", phase_err, m_err);
        chk("cnt4", cnt4, m_cnt % 16);
        chk("halt4", halt4, m_halt);
        chk("halted4", halted4, m_state == 2);
        chk("state4", state4, m_state);
        chk("step_done4", step_done4, m_done);
        chk("phase_err4", phase_err4, 0);
        chk("step_done0", step_done0, 0);
        chk("phase_err0", phase_err0, 0);
    end

    task automatic wait_halt(input logic want, input int budget, input string name);
        for (int i = 0; i < budget && halt !== want; i++) @(negedge clk);
        chk(name, halt, want);
    endtask

    task automatic do_step(input int n, output int pul, output int low,
                           output int dn, output bit ok);
        bit seen = 0;
        pul = 0; low = 0; dn = 0; ok = 0;
        @(negedge clk);
        step_n = n[7:0];
        step_req = 1;
        @(negedge clk);
        step_req = 0;
        for (int i = 0; i < 3 * (n == 0 ? 1 : n) + 12; i++) begin
            if (i > 0) @(negedge clk);
            if (step_done) dn++;
            if (!halt) begin
                seen = 1; low++;
                if (cyc) pul++;
            end else if (seen) begin
                ok = 1;
                break;
            end
        end
    endtask

    typedef struct {
        int n;
        int pulses;
        int low;
        int done;
    } step_vec_t;

    step_vec_t tbl[5];

    initial begin
        int pul, low, dn, seen3;
        bit ok;
        longint c0, mc0;

        tbl[0] = '{5, 5, 15, 1};
        tbl[1] = '{0, 1, 3, 1};
        tbl[2] = '{1, 1, 3, 1};
        tbl[3] = '{3, 3, 9, 1};
        tbl[4] = '{200, 200, 600, 1};

        // Reset, START_RUNNING=0 path, stop at clk 10
        repeat (3) @(negedge clk);
        rst = 0;
        chk("rst_halt", halt, 0);
        chk("rst_state", state, 0);
        chk("rst_cnt", cycle_cnt, 0);
        chk("rst_state0", state0, 1);
        repeat (2) @(negedge clk);
        chk("sr0_halt_e2", halt0, 0);
        @(negedge clk);
        chk("sr0_halt_e3", halt0, 1);
        chk("sr0_halted_e3", halted0, 1);
        chk("sr0_cnt_e3", cnt0, 1);
        repeat (6) @(negedge clk);
        halt_req = 1;
        @(negedge clk);
        halt_req = 0;
        chk("stop_e10", halt, 0);
        @(negedge clk);
        chk("stop_e11", halt, 0);
        @(negedge clk);
        chk("stop_e12", halt, 1);
        chk("stop_halted", halted, 1);
        chk("stop_cnt", cycle_cnt, 4);
        repeat (5) @(negedge clk);
        chk("frozen_ic", ic, 1);

        // Step table from HALTED
        foreach (tbl[i]) begin
            c0 = cycle_cnt;
            do_step(tbl[i].n, pul, low, dn, ok);
            chk($sformatf("step%0d_end", tbl[i].n), ok, 1);
            chk($sformatf("step%0d_pulses", tbl[i].n), pul, tbl[i].pulses);
            chk($sformatf("step%0d_low", tbl[i].n), low, tbl[i].low);
            chk($sformatf("step%0d_done", tbl[i].n), dn, tbl[i].done);
            chk($sformatf("step%0d_delta", tbl[i].n), cycle_cnt - c0, tbl[i].pulses);
        end

        // Abort a step of 100 with a breakpoint after 3 cycles
        c0 = cycle_cnt;
        mc0 = m_cnt;
        @(negedge clk);
        step_n = 100;
        step_req = 1;
        @(negedge clk);
        step_req = 0;
        seen3 = 0;
        dn = 0;
        for (int i = 0; i < 20 && seen3 < 3; i++) begin
            if (i > 0) @(negedge clk);
            if (cyc) seen3++;
        end
        chk("abort_3cyc", seen3, 3);
        bp_hit = 1;
        @(negedge clk);
        bp_hit = 0;
        for (int i = 0; i < 5 && !halt; i++) begin
            if (step_done) dn++;
            @(negedge clk);
        end
        if (step_done) dn++;
        chk("abort_halt", halt, 1);
        chk("abort_no_done", dn, 0);
        chk("abort_delta_model", cycle_cnt - c0, m_cnt - mc0);
        chk("abort_delta_range", (cycle_cnt - c0 == 3) || (cycle_cnt - c0 == 4), 1);

        // Simultaneous halt+run in RUN, then lone run in RUN
        @(negedge clk); run_req = 1;
        @(negedge clk); run_req = 0;
        wait_halt(0, 6, "resume_run");
        @(negedge clk); run_req = 1; halt_req = 1;
        @(negedge clk); run_req = 0; halt_req = 0;
        wait_halt(1, 6, "sim_halt");
        chk("sim_state", state, 2);
        @(negedge clk); run_req = 1;
        @(negedge clk); run_req = 0;
        wait_halt(0, 6, "resume_run2");
        @(negedge clk); run_req = 1;
        @(negedge clk); run_req = 0;
        repeat (6) @(negedge clk);
        chk("run_in_run_state", state, 0);
        chk("run_in_run_halt", halt, 0);

        // Reset in the middle of a step, then CNT_W=4 wrap
        @(negedge clk); halt_req = 1;
        @(negedge clk); halt_req = 0;
        wait_halt(1, 6, "pre_rst_halt");
        @(negedge clk); step_n = 50; step_req = 1;
        @(negedge clk); step_req = 0;
        repeat (10) @(negedge clk);
        chk("mid_step_state", state, 3);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("mrst_halt", halt, 0);
        chk("mrst_state", state, 0);
        chk("mrst_cnt", cycle_cnt, 0);
        chk("mrst_halt0", halt0, 0);
        chk("mrst_state0", state0, 1);
        dn = 0;
        repeat (48) begin
            @(negedge clk);
            if (step_done) dn++;
        end
        chk("mrst_no_done", dn, 0);
        chk("wrap_cnt32", cycle_cnt, 16);
        chk("wrap_cnt4", cnt4, 0);
        chk("mrst_halted0", halted0, 1);
        chk("mrst_cnt0", cnt0, 1);

        // Randomized requests against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            run_req   = ($urandom_range(0, 29) == 0);
            halt_req  = ($urandom_range(0, 59) == 0);
            step_req  = ($urandom_range(0, 24) == 0);
            bp_hit    = ($urandom_range(0, 99) == 0);
            hlt_instr = ($urandom_range(0, 99) == 0);
            step_n    = 8'($urandom_range(0, 6));
        end
        @(negedge clk);
        run_req = 0; halt_req = 0; step_req = 0; bp_hit = 0; hlt_instr = 0;

        // Lockstep violation while running
        @(negedge clk); halt_req = 1;
        @(negedge clk); halt_req = 0;
        wait_halt(1, 8, "lk_halt");
        @(negedge clk); run_req = 1;
        @(negedge clk); run_req = 0;
        wait_halt(0, 6, "lk_run");
        chk("lk_err_before", phase_err, 0);
        for (int i = 0; i < 5 && gph != 2'd1; i++) @(negedge clk);
        chk("lk_gph", gph, 1);
        ic_force = 1;
        @(negedge clk);
        ic_force = 0;
        chk("lk_err_set", phase_err, 1);
        repeat (10) @(negedge clk);
        chk("lk_err_sticky", phase_err, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("lk_err_rst", phase_err, 0);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
